// File: rtl/efuse_array_resp.sv
// efuse_array_resp: cycle-accurate stand-in for the efuse hard macro pins.
// Decodes aen strobes into byte reads and one-time single-bit programs on a
// 256-bit fuse array, and flags strobe timing violations.
// Optional feature macro: EFUSE_RESP_ERR_EN (error capture on err_o/err_code_o).
module efuse_array_resp #(
  parameter int unsigned  RD_LAT   = 2,
  parameter int unsigned  PGM_MIN  = 4,
  parameter logic [255:0] INIT_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         efuse_pgmen_i,
  input  logic         efuse_rden_i,
  input  logic         efuse_aen_i,
  input  logic [7:0]   efuse_addr_i,
  output logic [7:0]   efuse_rdata_o,
  output logic [255:0] fuse_bits_o,
  output logic         prog_done_o,
  input  logic         err_clr_i,
  output logic         err_o,
  output logic [1:0]   err_code_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_PGM
  } state_t;

  state_t         state_q;
  logic [3:0]     cnt_q;
  logic [7:0]     addr_q;
  logic [7:0]     rdata_q;
  logic [255:0]   fuse_q;
  logic           done_q;
  logic           aen_q;
  logic           rise;

  assign rise          = efuse_aen_i & ~aen_q;
  assign efuse_rdata_o = rdata_q;
  assign fuse_bits_o   = fuse_q;
  assign prog_done_o   = done_q;

  // Strobe decoder, counter, fuse array and registered read/program results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      fuse_q  <= INIT_VAL;
      done_q  <= 1'b0;
      aen_q   <= 1'b0;
    end else begin
      aen_q  <= efuse_aen_i;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rise && (efuse_rden_i != efuse_pgmen_i)) begin
            addr_q  <= efuse_addr_i;
            cnt_q   <= 4'd1;
            state_q <= efuse_rden_i ? S_READ : S_PGM;
          end
        end
        S_READ: begin
          if (!efuse_aen_i || !efuse_rden_i || efuse_pgmen_i) begin
            state_q <= S_IDLE;
          end else if (cnt_q == 4'(RD_LAT)) begin
            rdata_q <= fuse_q[{addr_q[7:3], 3'b000} +: 8];
            state_q <= S_IDLE;
          end else if (cnt_q != 4'd15) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_PGM: begin
          if (!efuse_aen_i) begin
            // Strobe width is the saturated count at the falling edge.
            if (cnt_q >= 4'(PGM_MIN)) begin
              fuse_q[addr_q] <= 1'b1;
              done_q         <= 1'b1;
            end
            state_q <= S_IDLE;
          end else if (!efuse_pgmen_i || efuse_rden_i) begin
            state_q <= S_IDLE;
          end else if (cnt_q != 4'd15) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef EFUSE_RESP_ERR_EN
  logic       err_ev;
  logic [1:0] err_ev_code;
  logic       err_q;
  logic [1:0] code_q;

  // Classify this cycle's protocol violation, mirroring the decoder's aborts.
  always_comb begin
    err_ev      = 1'b0;
    err_ev_code = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (rise && efuse_pgmen_i && efuse_rden_i) begin
          err_ev      = 1'b1;
          err_ev_code = 2'd1;
        end
      end
      S_READ: begin
        if (!efuse_aen_i) begin
          err_ev      = 1'b1;
          err_ev_code = 2'd2;
        end else if (!efuse_rden_i || efuse_pgmen_i) begin
          err_ev      = 1'b1;
          err_ev_code = 2'd3;
        end
      end
      S_PGM: begin
        if (!efuse_aen_i) begin
          if (cnt_q < 4'(PGM_MIN)) begin
            err_ev      = 1'b1;
            err_ev_code = 2'd2;
          end
        end else if (!efuse_pgmen_i || efuse_rden_i) begin
          err_ev      = 1'b1;
          err_ev_code = 2'd3;
        end
      end
      default: ;
    endcase
  end

  // Sticky error flag; code keeps the first error unless cleared in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= 1'b0;
      code_q <= '0;
    end else if (err_ev) begin
      err_q <= 1'b1;
      if (!err_q || err_clr_i) begin
        code_q <= err_ev_code;
      end
    end else if (err_clr_i) begin
      err_q  <= 1'b0;
      code_q <= '0;
    end
  end

  assign err_o      = err_q;
  assign err_code_o = code_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign err_o          = 1'b0;
  assign err_code_o     = '0;
`endif

endmodule

// File: tb/tb_efuse_array_resp.sv
module tb_efuse_array_resp;

`ifdef EFUSE_RESP_ERR_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         pgmen;
  logic         rden;
  logic         aen;
  logic [7:0]   addr;
  logic [7:0]   rdata;
  logic [255:0] fuse;
  logic         done;
  logic         err_clr;
  logic         err;
  logic [1:0]   code;

  int total = 0;
  int bad   = 0;

  logic [255:0] exp_fuse;
  logic         d_pulse, d_late;
  logic [7:0]   r_before, r_at;

  efuse_array_resp #(
    .RD_LAT   (2),
    .PGM_MIN  (4),
    .INIT_VAL ('0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .efuse_pgmen_i (pgmen),
    .efuse_rden_i  (rden),
    .efuse_aen_i   (aen),
    .efuse_addr_i  (addr),
    .efuse_rdata_o (rdata),
    .fuse_bits_o   (fuse),
    .prog_done_o   (done),
    .err_clr_i     (err_clr),
    .err_o         (err),
    .err_code_o    (code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Program strobe of w cycles; addr input is scrambled after the rise.
  task automatic do_pgm(input logic [7:0] a, input int w);
    pgmen = 1'b1; addr = a; aen = 1'b1;
    step();
    addr = ~a;
    repeat (w - 1) step();
    aen = 1'b0;
    step();
    d_pulse = done;
    pgmen = 1'b0; addr = '0;
    step();
    d_late = done;
  endtask

  // Read strobe held through the load; rdata sampled one clock early and on time.
  task automatic do_read(input logic [7:0] a);
    rden = 1'b1; addr = a; aen = 1'b1;
    step();
    addr = 8'h00;
    step();
    r_before = rdata;
    step();
    r_at = rdata;
    aen = 1'b0; rden = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pgmen = 0; rden = 0; aen = 0; addr = '0; err_clr = 0;
    exp_fuse = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (code !== 2'd0) begin bad++; $display("FAIL reset_code got=%0d exp=0", code); end
    total++; if (fuse !== exp_fuse) begin bad++; $display("FAIL reset_fuse got=%h exp=%h", fuse, exp_fuse); end
  endtask

  task automatic test_program();
    do_pgm(8'h08, 4);
    exp_fuse[8] = 1'b1;
    total++; if (d_pulse !== 1'b1) begin bad++; $display("FAIL pgm8_done got=%b exp=1", d_pulse); end
    total++; if (d_late !== 1'b0) begin bad++; $display("FAIL pgm8_done_width got=%b exp=0", d_late); end
    total++; if (fuse !== exp_fuse) begin bad++; $display("FAIL pgm8_fuse got=%h exp=%h", fuse, exp_fuse); end
    do_read(8'h08);
    total++; if (r_before !== 8'h00) begin bad++; $display("FAIL rd8_early got=%h exp=00", r_before); end
    total++; if (r_at !== 8'h01) begin bad++; $display("FAIL rd8_data got=%h exp=01", r_at); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rd8_err got=%b exp=0", err); end
  endtask

  task automatic test_short_pgm();
    do_pgm(8'h10, 3);
    total++; if (d_pulse !== 1'b0) begin bad++; $display("FAIL short_done got=%b exp=0", d_pulse); end
    total++; if (fuse !== exp_fuse) begin bad++; $display("FAIL short_fuse got=%h exp=%h", fuse, exp_fuse); end
    total++; if (err !== EN) begin bad++; $display("FAIL short_err got=%b exp=%b", err, EN); end
    total++; if (code !== (EN ? 2'd2 : 2'd0)) begin bad++; $display("FAIL short_code got=%0d exp=%0d", code, EN ? 2 : 0); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL clr_err got=%b exp=0", err); end
    total++; if (code !== 2'd0) begin bad++; $display("FAIL clr_code got=%0d exp=0", code); end
  endtask

  task automatic test_both_enables();
    do_pgm(8'h10, 2);
    // Clear coincides with a new both-enables error: the new error must win.
    pgmen = 1'b1; rden = 1'b1; aen = 1'b1; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    total++; if (err !== EN) begin bad++; $display("FAIL both_err got=%b exp=%b", err, EN); end
    total++; if (code !== (EN ? 2'd1 : 2'd0)) begin bad++; $display("FAIL both_code got=%0d exp=%0d", code, EN ? 1 : 0); end
    aen = 1'b0; pgmen = 1'b0; rden = 1'b0;
    step();
    total++; if (rdata !== 8'h01) begin bad++; $display("FAIL both_rdata got=%h exp=01", rdata); end
    total++; if (fuse !== exp_fuse) begin bad++; $display("FAIL both_fuse got=%h exp=%h", fuse, exp_fuse); end
    do_pgm(8'h10, 1);
    total++; if (code !== (EN ? 2'd1 : 2'd0)) begin bad++; $display("FAIL first_code_kept got=%0d exp=%0d", code, EN ? 1 : 0); end
    total++; if (fuse !== exp_fuse) begin bad++; $display("FAIL bad_strobe_fuse got=%h exp=%h", fuse, exp_fuse); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
  endtask

  task automatic test_midop_change();
    rden = 1'b1; addr = 8'h00; aen = 1'b1;
    step();
    rden = 1'b0;
    step();
    total++; if (code !== (EN ? 2'd3 : 2'd0)) begin bad++; $display("FAIL midop_code got=%0d exp=%0d", code, EN ? 3 : 0); end
    aen = 1'b0;
    repeat (3) step();
    total++; if (rdata !== 8'h01) begin bad++; $display("FAIL midop_rdata got=%h exp=01", rdata); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
  endtask

  task automatic test_boundary();
    do_pgm(8'hFF, 17);
    exp_fuse[255] = 1'b1;
    total++; if (d_pulse !== 1'b1) begin bad++; $display("FAIL sat_done got=%b exp=1", d_pulse); end
    total++; if (fuse !== exp_fuse) begin bad++; $display("FAIL sat_fuse got=%h exp=%h", fuse, exp_fuse); end
    do_read(8'hFF);
    total++; if (r_before !== 8'h01) begin bad++; $display("FAIL rdff_early got=%h exp=01", r_before); end
    total++; if (r_at !== 8'h80) begin bad++; $display("FAIL rdff_data got=%h exp=80", r_at); end
    do_read(8'h0F);
    total++; if (r_at !== 8'h01) begin bad++; $display("FAIL rd0f_data got=%h exp=01", r_at); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL boundary_err got=%b exp=0", err); end
  endtask

  task automatic test_reprogram_reset();
    do_pgm(8'h08, 4);
    total++; if (d_pulse !== 1'b1) begin bad++; $display("FAIL repgm_done got=%b exp=1", d_pulse); end
    total++; if (fuse !== exp_fuse) begin bad++; $display("FAIL repgm_fuse got=%h exp=%h", fuse, exp_fuse); end
    pgmen = 1'b1; addr = 8'h20; aen = 1'b1;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    exp_fuse = '0;
    total++; if (fuse !== exp_fuse) begin bad++; $display("FAIL rst_fuse got=%h exp=%h", fuse, exp_fuse); end
    aen = 1'b0; pgmen = 1'b0;
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    rst_n = 1'b1;
    repeat (2) step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done_after got=%b exp=0", done); end
    total++; if (fuse !== exp_fuse) begin bad++; $display("FAIL rst_fuse_after got=%h exp=%h", fuse, exp_fuse); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h exp=00", rdata); end
  endtask

  initial begin
    test_reset();
    test_program();
    test_short_pgm();
    test_both_enables();
    test_midop_change();
    test_boundary();
    test_reprogram_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
